// File: rtl/program_rom.sv
// program_rom: 256-byte CPU program memory with an edge-triggered editor write port,
// a registered 32-bit fetch port and a FILL sweep after reset or clear (PROGRAM_ROM_READBACK_EN adds editor readback).
module program_rom #(
    parameter logic [7:0] FILL  = 8'h00,
    parameter int          DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        edit,
    input  logic [7:0]  unit,
    input  logic [7:0]  code,
    input  logic        send,
    input  logic [7:0]  fetch_addr,
    output logic [31:0] fetch_data,
    output logic        busy,
    output logic        wr_ack,
    output logic        wr_drop,
    output logic [7:0]  rd_data
);

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_READY = 1'b1;

    logic        r_state;
    logic [7:0]  r_ca;
    logic        r_send_q;
    logic        r_wr_ack;
    logic        r_wr_drop;
    logic [31:0] r_fetch_data;
    logic [7:0]  r_mem [0:DEPTH-1];

    logic        w_send_rise;
    logic        w_accept;
    logic        w_reject;
    logic        w_sweep_we;
    logic [7:0]  w_fa1;
    logic [7:0]  w_fa2;
    logic [7:0]  w_fa3;

    assign w_send_rise = send & ~r_send_q;
    assign w_accept    = w_send_rise & edit & (r_state == ST_READY) & ~clear;
    assign w_reject    = w_send_rise & edit & ~w_accept;
    // A cycle with clear high only rewinds the counter; the sweep writes start on the next edge.
    assign w_sweep_we  = (r_state == ST_CLEAR) & ~clear;

    assign w_fa1 = fetch_addr + 8'd1;
    assign w_fa2 = fetch_addr + 8'd2;
    assign w_fa3 = fetch_addr + 8'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_ca    <= 8'd0;
        end else if (clear) begin
            r_state <= ST_CLEAR;
            r_ca    <= 8'd0;
        end else if (r_state == ST_CLEAR) begin
            r_ca <= r_ca + 8'd1;
            if (r_ca == 8'hFF) begin
                r_state <= ST_READY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_send_q  <= 1'b0;
            r_wr_ack  <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            r_send_q  <= send;
            r_wr_ack  <= w_accept;
            r_wr_drop <= w_reject;
        end
    end

    // Sweep and editor writes are mutually exclusive by state, so one write port suffices.
    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_mem[r_ca] <= FILL;
        end else if (w_accept) begin
            r_mem[unit] <= code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_data <= 32'd0;
        end else begin
            r_fetch_data <= {r_mem[fetch_addr], r_mem[w_fa1], r_mem[w_fa2], r_mem[w_fa3]};
        end
    end

`ifdef PROGRAM_ROM_READBACK_EN
    logic [7:0] r_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 8'd0;
        end else if (edit) begin
            r_rd_data <= r_mem[unit];
        end
    end

    assign rd_data = r_rd_data;
`else
    assign rd_data = 8'd0;
`endif

    assign fetch_data = r_fetch_data;
    assign busy       = (r_state == ST_CLEAR);
    assign wr_ack     = r_wr_ack;
    assign wr_drop    = r_wr_drop;

endmodule
